tmds_encoder: RTL



---
 rtl/tmds_encoder.sv | 117 +++++++++++
 1 files changed

// File: rtl/tmds_encoder.sv
// DVI 1.0 TMDS 8b/10b channel encoder: two-stage pipeline with a running
// DC-balance counter that is cleared during control periods.
module tmds_encoder #(
    parameter int unsigned CNT_WIDTH = 5
) (
    input  logic                        clk_i,
    input  logic                        rstn_i,
    input  logic [7:0]                  data_i,
    input  logic                        c0_i,
    input  logic                        c1_i,
    input  logic                        de_i,
    output logic [9:0]                  tmds_o,
    output logic signed [CNT_WIDTH-1:0] disparity_o
);

    localparam logic [9:0] Ctrl00 = 10'b1101010100;
    localparam logic [9:0] Ctrl01 = 10'b0010101011;
    localparam logic [9:0] Ctrl10 = 10'b0101010100;
    localparam logic [9:0] Ctrl11 = 10'b1010101011;
    localparam logic signed [CNT_WIDTH-1:0] CntTwo = CNT_WIDTH'(2);

    // Stage 1: transition-minimising q_m
    logic [8:0] q_m_d, q_m_q;
    logic       de_q, c0_q, c1_q;
    logic [3:0] n1;
    logic       xnor_sel;
    logic       acc;

    always_comb begin
        n1 = '0;
        for (int i = 0; i < 8; i++) begin
            n1 = n1 + {3'b000, data_i[i]};
        end
        xnor_sel = (n1 > 4'd4) || ((n1 == 4'd4) && !data_i[0]);
        acc      = data_i[0];
        q_m_d    = '0;
        q_m_d[0] = acc;
        for (int i = 1; i < 8; i++) begin
            acc      = acc ^ data_i[i] ^ xnor_sel;
            q_m_d[i] = acc;
        end
        q_m_d[8] = ~xnor_sel;
        // Blank q_m outside data periods so undriven pixel data never enters the pipe
        if (!de_i) begin
            q_m_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            q_m_q <= '0;
            de_q  <= 1'b0;
            c0_q  <= 1'b0;
            c1_q  <= 1'b0;
        end else begin
            q_m_q <= q_m_d;
            de_q  <= de_i;
            c0_q  <= c0_i;
            c1_q  <= c1_i;
        end
    end

    // Stage 2: DC balancing
    logic [9:0]                  tmds_d, tmds_q;
    logic signed [CNT_WIDTH-1:0] cnt_d, cnt_q;
    logic signed [CNT_WIDTH-1:0] diff;
    logic [3:0]                  n1q;
    logic                        qm8;
    logic                        cnt_zero, cnt_pos, cnt_neg;

    always_comb begin
        n1q = '0;
        for (int i = 0; i < 8; i++) begin
            n1q = n1q + {3'b000, q_m_q[i]};
        end
        qm8      = q_m_q[8];
        // diff = n1q - n0q = 2*n1q - 8
        diff     = CNT_WIDTH'(n1q) + CNT_WIDTH'(n1q) - CNT_WIDTH'(8);
        cnt_zero = (cnt_q == '0);
        cnt_neg  = cnt_q[CNT_WIDTH-1];
        cnt_pos  = !cnt_neg && !cnt_zero;
        tmds_d   = Ctrl00;
        cnt_d    = cnt_q;
        if (!de_q) begin
            unique case ({c1_q, c0_q})
                2'b00: tmds_d = Ctrl00;
                2'b01: tmds_d = Ctrl01;
                2'b10: tmds_d = Ctrl10;
                2'b11: tmds_d = Ctrl11;
            endcase
            cnt_d = '0;
        end else if (cnt_zero || (n1q == 4'd4)) begin
            tmds_d = {~qm8, qm8, qm8 ? q_m_q[7:0] : ~q_m_q[7:0]};
            cnt_d  = qm8 ? (cnt_q + diff) : (cnt_q - diff);
        end else if ((cnt_pos && (n1q > 4'd4)) || (cnt_neg && (n1q < 4'd4))) begin
            tmds_d = {1'b1, qm8, ~q_m_q[7:0]};
            cnt_d  = cnt_q - diff + (qm8 ? CntTwo : '0);
        end else begin
            tmds_d = {1'b0, qm8, q_m_q[7:0]};
            cnt_d  = cnt_q + diff - (qm8 ? '0 : CntTwo);
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            tmds_q <= Ctrl00;
            cnt_q  <= '0;
        end else begin
            tmds_q <= tmds_d;
            cnt_q  <= cnt_d;
        end
    end

    assign tmds_o      = tmds_q;
    assign disparity_o = cnt_q;

endmodule
